// File: rtl/tx_inband_pkg.sv
// rtl/tx_inband_pkg.sv - shared constants and helpers for the inband TX path
package tx_inband_pkg;
   localparam int MAX_CHAN         = 4;
   localparam int SAMPLE_W_DEFAULT = 16;
   localparam int RATE_W_DEFAULT   = 8;
   localparam int UCNT_W_DEFAULT   = 8;

   // 32-bit container so any counter up to 32 bits can share it; callers truncate back.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
      return (value >= max_value) ? max_value : value + 32'd1;
   endfunction
endpackage

// File: rtl/tx_strobe_div.sv
// rtl/tx_strobe_div.sv - per-channel strobe divider with sticky underrun status
module tx_strobe_div
   import tx_inband_pkg::*;
#(
   parameter int RATE_W = RATE_W_DEFAULT,
   parameter int UCNT_W = UCNT_W_DEFAULT
) (
   input  logic              txclk,
   input  logic              reset,
   input  logic              txstrobe,
   input  logic              enable,
   input  logic [RATE_W-1:0] rate,
   input  logic              txempty,
   input  logic              clear_status,
   output logic              chan_txstrobe,
   output logic              tx_underrun,
   output logic [UCNT_W-1:0] underrun_cnt
);
   localparam logic [UCNT_W-1:0] UCNT_MAX = '1;

   logic [RATE_W-1:0] cnt;
   logic [RATE_W-1:0] last;
   logic [UCNT_W-1:0] cnt_inc;
   logic              underrun_event;

   // Rate 0 behaves as rate 1; >= lets a mid-count rate reduction wrap at once.
   assign last           = (rate == '0) ? '0 : rate - RATE_W'(1);
   assign underrun_event = enable & chan_txstrobe & txempty;
   assign cnt_inc        = UCNT_W'(sat_inc(32'(underrun_cnt), 32'(UCNT_MAX)));

   always_ff @(posedge txclk or negedge reset) begin
      if (!reset) begin
         cnt           <= '0;
         chan_txstrobe <= 1'b0;
      end else if (!enable) begin
         cnt           <= '0;
         chan_txstrobe <= 1'b0;
      end else if (txstrobe) begin
         if (cnt >= last) begin
            cnt           <= '0;
            chan_txstrobe <= 1'b1;
         end else begin
            cnt           <= cnt + RATE_W'(1);
            chan_txstrobe <= 1'b0;
         end
      end else begin
         chan_txstrobe <= 1'b0;
      end
   end

   // A clear that coincides with an event restarts the status at that event.
   always_ff @(posedge txclk or negedge reset) begin
      if (!reset) begin
         tx_underrun  <= 1'b0;
         underrun_cnt <= '0;
      end else if (clear_status) begin
         tx_underrun  <= underrun_event;
         underrun_cnt <= underrun_event ? UCNT_W'(1) : '0;
      end else if (underrun_event) begin
         tx_underrun  <= 1'b1;
         underrun_cnt <= cnt_inc;
      end
   end
endmodule

// File: rtl/tx_chan_outstage.sv
// rtl/tx_chan_outstage.sv - multi-channel TX output stage with gating, status and reductions
module tx_chan_outstage
   import tx_inband_pkg::*;
#(
   parameter int NUM_CHAN = 2,
   parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
   parameter int RATE_W   = RATE_W_DEFAULT,
   parameter int UCNT_W   = UCNT_W_DEFAULT
) (
   input  logic                         txclk,
   input  logic                         reset,
   input  logic                         txstrobe,
   input  logic [NUM_CHAN-1:0]          chan_enable,
   input  logic [NUM_CHAN*RATE_W-1:0]   strobe_rate,
   input  logic [NUM_CHAN*SAMPLE_W-1:0] chan_i,
   input  logic [NUM_CHAN*SAMPLE_W-1:0] chan_q,
   input  logic [NUM_CHAN-1:0]          chan_txempty,
   input  logic [NUM_CHAN-1:0]          chan_have_space,
   input  logic                         cmd_have_space,
   input  logic                         clear_status,
   output logic [NUM_CHAN-1:0]          chan_txstrobe,
   output logic [NUM_CHAN*SAMPLE_W-1:0] tx_i,
   output logic [NUM_CHAN*SAMPLE_W-1:0] tx_q,
   output logic [NUM_CHAN-1:0]          tx_underrun,
   output logic [NUM_CHAN*UCNT_W-1:0]   underrun_cnt,
   output logic [31:0]                  adc_time,
   output logic                         have_space,
   output logic                         tx_empty
);
   logic [NUM_CHAN-1:0]          sample_ok;
   logic [NUM_CHAN*SAMPLE_W-1:0] gated_i;
   logic [NUM_CHAN*SAMPLE_W-1:0] gated_q;
   logic                         have_space_c;
   logic                         tx_empty_c;

   assign sample_ok    = chan_enable & ~chan_txempty;
   // Disabled channels never hold back the reductions.
   assign have_space_c = cmd_have_space & (&(chan_have_space | ~chan_enable));
   assign tx_empty_c   = &(chan_txempty | ~chan_enable);

   for (genvar k = 0; k < NUM_CHAN; k++) begin : g_chan
      assign gated_i[k*SAMPLE_W +: SAMPLE_W] = sample_ok[k] ? chan_i[k*SAMPLE_W +: SAMPLE_W] : '0;
      assign gated_q[k*SAMPLE_W +: SAMPLE_W] = sample_ok[k] ? chan_q[k*SAMPLE_W +: SAMPLE_W] : '0;

      tx_strobe_div #(
         .RATE_W (RATE_W),
         .UCNT_W (UCNT_W)
      ) u_strobe_div (
         .txclk         (txclk),
         .reset         (reset),
         .txstrobe      (txstrobe),
         .enable        (chan_enable[k]),
         .rate          (strobe_rate[k*RATE_W +: RATE_W]),
         .txempty       (chan_txempty[k]),
         .clear_status  (clear_status),
         .chan_txstrobe (chan_txstrobe[k]),
         .tx_underrun   (tx_underrun[k]),
         .underrun_cnt  (underrun_cnt[k*UCNT_W +: UCNT_W])
      );
   end

   always_ff @(posedge txclk or negedge reset) begin
      if (!reset) begin
         tx_i       <= '0;
         tx_q       <= '0;
         adc_time   <= '0;
         have_space <= 1'b0;
         tx_empty   <= 1'b1;
      end else begin
         tx_i       <= gated_i;
         tx_q       <= gated_q;
         have_space <= have_space_c;
         tx_empty   <= tx_empty_c;
         if (txstrobe) begin
            adc_time <= adc_time + 32'd1;
         end
      end
   end
endmodule

// File: doc/tx_chan_outstage.md
Name: tx_chan_outstage

Overview:
- Parametrised per-channel TX output stage for the inband TX path, placed between the NUM_CHAN channel FIFO readers and the DAC-side tx_i/tx_q outputs.
- Generalises the fixed 1–2 channel aggregation to NUM_CHAN channels, with a per-channel enable and a per-channel programmable strobe divider.
- Produces registered, zero-gated sample outputs, sticky underrun flags with saturating counters, the shared adc_time counter, and have_space/tx_empty reductions over the enabled channels.

Parameters:
- NUM_CHAN, 2, number of data channels (1..4).
- SAMPLE_W, 16, I/Q sample width.
- RATE_W, 8, strobe divider rate width.
- UCNT_W, 8, per-channel underrun counter width.

Ports:
- txclk  in  1  TX clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- txstrobe  in  1  base sample strobe.
- chan_enable  in  NUM_CHAN  per-channel enable.
- strobe_rate  in  NUM_CHAN*RATE_W  per-channel divide ratio; channel k occupies bits [k*RATE_W +: RATE_W].
- chan_i  in  NUM_CHAN*SAMPLE_W  reader I samples, packed as for strobe_rate.
- chan_q  in  NUM_CHAN*SAMPLE_W  reader Q samples, packed.
- chan_txempty  in  NUM_CHAN  reader has no valid sample.
- chan_have_space  in  NUM_CHAN  per-channel RAM space flag.
- cmd_have_space  in  1  command RAM space flag.
- clear_status  in  1  single-cycle pulse; clears underrun status.
- chan_txstrobe  out  NUM_CHAN  divided strobe to each reader.
- tx_i  out  NUM_CHAN*SAMPLE_W  gated I outputs.
- tx_q  out  NUM_CHAN*SAMPLE_W  gated Q outputs.
- tx_underrun  out  NUM_CHAN  sticky underrun flags.
- underrun_cnt  out  NUM_CHAN*UCNT_W  saturating underrun counts.
- adc_time  out  32  count of txstrobe pulses.
- have_space  out  1  space-available reduction.
- tx_empty  out  1  all-empty reduction.

Behaviour:
- Reset (reset=0, asynchronous): every output is 0 except tx_empty=1. All divider counters are 0.
- adc_time:
  - Increments by 1 in each cycle with txstrobe=1.
  - Wraps from 0xFFFFFFFF to 0.
- Strobe divider, per channel k, with R = strobe_rate[k]; R=0 is treated as R=1.
  - Channel disabled: counter is forced to 0 and chan_txstrobe[k]=0.
  - Enabled, on txstrobe: if cnt >= R-1, then cnt<=0 and chan_txstrobe[k]<=1 on the next cycle. Otherwise cnt<=cnt+1.
  - chan_txstrobe[k] is registered: a one-cycle pulse, 1 cycle after the qualifying txstrobe.
  - The ">=" compare means a rate reduction applied mid-count wraps on the next txstrobe; there is no lock-up.
  - R=1 gives chan_txstrobe[k] as txstrobe delayed by 1 cycle.
- Sample gating, per channel, registered with 1-cycle latency:
  - If chan_enable[k]=0 or chan_txempty[k]=1, then tx_i[k] and tx_q[k] are 0.
  - Otherwise they load chan_i[k] and chan_q[k].
- Underrun detection, per channel:
  - An event occurs when chan_txstrobe[k]=1 and chan_txempty[k]=1 in the same cycle, with chan_enable[k]=1.
  - On an event: tx_underrun[k]<=1 and the counter increments, saturating at 2^UCNT_W-1.
  - clear_status with no event: flag<=0 and count<=0.
  - clear_status with a simultaneous event: flag<=1 and count<=1, so the new event is not lost.
  - Disabling a channel does not clear its status.
- Reductions, registered with 1-cycle latency:
  - have_space = cmd_have_space AND (AND over k of (chan_have_space[k] OR NOT chan_enable[k])).
  - tx_empty = AND over k of (chan_txempty[k] OR NOT chan_enable[k]).
  - With no channel enabled: have_space follows cmd_have_space and tx_empty=1.
- Reset asserted mid-operation: all state returns to the reset values immediately. The first strobe after release follows the divider rules from cnt=0.

Decomposition:
- Shared package tx_inband_pkg holds:
  - MAX_CHAN=4
  - default SAMPLE_W, RATE_W and UCNT_W
  - the saturating-increment function
- One sub-module, tx_strobe_div, generated NUM_CHAN times. It contains the divider counter, the chan_txstrobe register and the underrun flag/counter.
- Sample gating, the reductions and adc_time stay in the top module.

Test Plan:
- Reset, then NUM_CHAN=2, both channels enabled, rates 1 and 3, txstrobe on every cycle for 12 cycles:
  - chan_txstrobe[0] is 1 on every cycle from cycle 1.
  - chan_txstrobe[1] pulses on cycles 3, 6, 9, 12.
  - adc_time=12.
- Rate for channel 1 set to 4, then changed to 2 while cnt=3: chan_txstrobe[1] pulses on the next txstrobe, then every 2 strobes.
- chan_txempty[1]=1 during 5 channel-1 strobes with UCNT_W=2:
  - tx_underrun[1]=1.
  - underrun_cnt[1] saturates at 3.
  - tx_i[1] and tx_q[1] stay 0.
- clear_status asserted in the same cycle as an underrun event: tx_underrun=1 and count=1. A clear alone afterwards gives 0 and 0.
- Channel 1 disabled, chan_have_space[1]=0, chan_txempty[1]=0, with chan_have_space[0]=1, cmd_have_space=1, chan_txempty[0]=1:
  - have_space=1 and tx_empty=1 one cycle later.
  - chan_txstrobe[1] stays 0.
- chan_i[0]=16'h1234 with chan_txempty[0]=0: tx_i[0]=16'h1234 one cycle later. reset=0 mid-stream clears tx_i[0] to 0 asynchronously.
